// File: rtl/sa_params_pkg.sv
// Shared constants and the fill FSM state type for the stream-to-BRAM fill path.
package sa_params_pkg;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_WAIT_DONE
  } fill_state_e;
endpackage

// File: rtl/bram_fill_ctrl_if.sv
// Upstream word stream plus the segment request/write handshake to the ping-pong buffer.
// master = fill controller side, slave = stream source and ping-pong buffer side.
interface bram_fill_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [31:0]       seg_words;
  logic              fill_req;
  logic              fill_busy;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_wdata;
  logic              fill_done;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fill_busy, fill_done,
    output s_axis_tready, seg_words, fill_req, fill_we, fill_addr, fill_wdata
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fill_busy, fill_done,
    input  s_axis_tready, seg_words, fill_req, fill_we, fill_addr, fill_wdata
  );
endinterface

// File: rtl/bram_fill_ctrl.sv
// Splits a stream of total_words into DEPTH-sized segments written into a ping-pong bank.
// Optional tlast consistency checking is enabled by defining FILL_TLAST_CHECK_EN.
module bram_fill_ctrl
  import sa_params_pkg::*;
#(
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         total_words,
  output logic                busy,
  output logic                done,
  output logic                tlast_err,
  bram_fill_ctrl_if.master    bus
);

  fill_state_e state_q, state_d;
  logic [31:0] remaining_q;
  logic [31:0] wc_q;
  logic [31:0] seg_q;
  logic        busy_q;
  logic        done_q;
  logic        hs;

  assign hs            = (state_q == S_STREAM) && bus.s_axis_tvalid;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.seg_words = seg_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.fill_req      = 1'b0;
    bus.s_axis_tready = 1'b0;
    bus.fill_we       = 1'b0;
    bus.fill_addr     = '0;
    bus.fill_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        if (start && (total_words != 32'd0)) state_d = S_REQ;
      end
      S_REQ: begin
        bus.fill_req = 1'b1;
        if (bus.fill_busy) state_d = S_STREAM;
      end
      S_STREAM: begin
        bus.s_axis_tready = 1'b1;
        bus.fill_we       = bus.s_axis_tvalid;
        bus.fill_addr     = wc_q[ADDR_W-1:0];
        bus.fill_wdata    = bus.s_axis_tdata;
        if (hs && (wc_q == seg_q - 32'd1)) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.fill_done) state_d = (remaining_q != 32'd0) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // seg_q is only loaded on the transitions into S_REQ so it stays stable for a whole segment
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      wc_q        <= '0;
      seg_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= total_words;
            seg_q       <= (total_words > 32'(DEPTH)) ? 32'(DEPTH) : total_words;
            if (total_words == 32'd0) done_q <= 1'b1;
            else                      busy_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.fill_busy) wc_q <= '0;
        end
        S_STREAM: begin
          if (hs) begin
            wc_q <= wc_q + 32'd1;
            if (remaining_q != 32'd0) remaining_q <= remaining_q - 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.fill_done) begin
            if (remaining_q != 32'd0) begin
              seg_q <= (remaining_q > 32'(DEPTH)) ? 32'(DEPTH) : remaining_q;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FILL_TLAST_CHECK_EN
  logic tlast_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tlast_err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      tlast_err_q <= 1'b0;
    end else if (hs && (bus.s_axis_tlast != (remaining_q == 32'd1))) begin
      tlast_err_q <= 1'b1;
    end
  end

  assign tlast_err = tlast_err_q;
`else
  assign tlast_err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fill_ctrl.sv
// Randomized bench for bram_fill_ctrl with a behavioural ping-pong buffer and word scoreboard.
module tb_bram_fill_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
`ifdef FILL_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] total_words;
  logic        busy;
  logic        done;
  logic        tlast_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  bram_fill_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_fill_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .total_words (total_words),
    .busy        (busy),
    .done        (done),
    .tlast_err   (tlast_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One transfer: stream source with random gaps, buffer model granting after `stall` cycles,
  // optional reset after rst_at words, optional misplaced tlast, optional start while busy.
  task automatic run_xfer(input int total, input int gap_max, input int stall,
                          input int rst_at, input int bad_last, input bit poke);
    logic [DATA_W-1:0] words[$];
    int wr = 0, seg_wr = 0, seg_len = 0, gap = 0, bst = 0, dly = 0, nseg = 0;
    int cyc = 0, post_rst = -1, rem;
    bit pend_done = 0, fd_last = 0, exp_done = 0, exp_err = 0, finished = 0;
    bit poked = 0, first = 1;
    for (int i = 0; i < total; i++) words.push_back($urandom);

    @(negedge clk);
    start = 1'b1; total_words = total; bus.s_axis_tvalid = 1'b0;
    while (!finished) begin
      @(negedge clk);
      start = 1'b0; rst = 1'b0; bus.fill_done = 1'b0;
      exp_done = fd_last; fd_last = 0;
      if (post_rst >= 0) begin
        bus.s_axis_tvalid = 1'b0;
        #1;
        if (post_rst == 0) begin
          chk("rst_busy", busy, 0);
          chk("rst_req", bus.fill_req, 0);
          chk("rst_rdy", bus.s_axis_tready, 0);
          chk("rst_seg", bus.seg_words, 0);
          chk("rst_we", bus.fill_we, 0);
        end
        chk("rst_no_done", done, 0);
        post_rst++;
        if (post_rst == 4) finished = 1;
        continue;
      end
      if (rst_at >= 0 && wr == rst_at) begin
        rst = 1'b1; post_rst = 0; bus.fill_busy = 1'b0; bus.s_axis_tvalid = 1'b0;
        continue;
      end
      if (poke && !poked && wr == 10) begin
        start = 1'b1; total_words = 5; poked = 1;
      end
      if (pend_done) begin
        bus.fill_done = 1'b1; bus.fill_busy = 1'b0; bst = 0; pend_done = 0;
        fd_last = (wr == total);
      end else if (bst == 1) begin
        if (dly == 0) begin bus.fill_busy = 1'b1; bst = 2; end
        else dly--;
      end
      bus.s_axis_tvalid = (gap == 0) && (wr < total);
      if (gap > 0) gap--;
      if (wr < total) begin
        bus.s_axis_tdata = words[wr];
        bus.s_axis_tlast = (bad_last >= 0) ? (wr == bad_last) : (wr == total - 1);
      end
      #1;
      if (first) begin chk("busy_start", busy, 1); first = 0; end
      chk("done", done, exp_done);
      if (exp_done) begin chk("busy_end", busy, 0); finished = 1; end
      chk("tlast_err", tlast_err, exp_err);
      if (bst == 0 && bus.fill_req) begin
        rem = total - wr;
        seg_len = (rem > DEPTH) ? DEPTH : rem;
        chk("seg_words", bus.seg_words, seg_len);
        seg_wr = 0; dly = stall; bst = 1; nseg++;
      end
      if (bst == 1) begin
        chk("stall_req", bus.fill_req, 1);
        chk("stall_rdy", bus.s_axis_tready, 0);
      end
      chk("we_hs", bus.fill_we, bus.s_axis_tvalid & bus.s_axis_tready);
      if (bus.fill_we) begin
        if (wr < total) begin
          chk("wdata", bus.fill_wdata, words[wr]);
          chk("addr", bus.fill_addr, seg_wr);
          if (TLAST_CHK && (bus.s_axis_tlast != (total - wr == 1))) exp_err = 1;
        end else begin
          chk("overrun", 1, 0);
        end
        wr++; seg_wr++;
        gap = $urandom_range(0, gap_max);
        if (seg_wr == seg_len) pend_done = 1;
      end
      cyc++;
      if (cyc > 5000) begin chk("timeout", 0, 1); finished = 1; end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.fill_busy = 1'b0;
    if (rst_at < 0) begin
      chk("words_total", wr, total);
      chk("seg_count", nseg, (total + DEPTH - 1) / DEPTH);
      @(negedge clk); #1;
      chk("idle_req", bus.fill_req, 0);
      chk("idle_done", done, 0);
      chk("idle_err", tlast_err, exp_err);
    end
  endtask

  task automatic run_zero();
    @(negedge clk);
    start = 1'b1; total_words = 0;
    #1;
    chk("zero_req0", bus.fill_req, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req1", bus.fill_req, 0);
    @(negedge clk); #1;
    chk("zero_done_off", done, 0);
    chk("zero_req2", bus.fill_req, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; total_words = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.fill_busy = 1'b0; bus.fill_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", tlast_err, 0);
    chk("reset_req", bus.fill_req, 0);
    chk("reset_we", bus.fill_we, 0);
    chk("reset_rdy", bus.s_axis_tready, 0);
    chk("reset_seg", bus.seg_words, 0);
    chk("reset_addr", bus.fill_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(150, 0, 0, -1, -1, 1'b0);
    run_xfer(100, 5, 0, -1, -1, 1'b1);
    run_xfer(70, 2, 20, -1, -1, 1'b0);
    run_zero();
    run_xfer(10, 0, 0, -1, 4, 1'b0);
    run_xfer(5, 1, 1, -1, -1, 1'b0);
    run_xfer(64, 0, 0, 30, -1, 1'b0);
    run_xfer(64, 1, 2, -1, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_xfer($urandom_range(1, 200), $urandom_range(0, 3), $urandom_range(0, 4), -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
